// File: rtl/cpu.sv
// Two-cycle Hack CPU: FETCH presents PC to the instruction ROM, and EXEC consumes inst/in_m and commits A, D and PC.
// RAM and ROM are external synchronous memories. The word at A==0x6000 reads back the switches.
module cpu (
  input  logic        clk,
  input  logic        resetN,
  input  logic [3:0]  SW,
  input  logic [15:0] inst,
  input  logic [15:0] in_m,
  output logic [15:0] out_m,
  output logic        write_m,
  output logic [9:0]  data_addr,
  output logic [9:0]  inst_addr
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [15:0] a_reg, a_next;
  logic [15:0] d_reg, d_next;
  logic [14:0] pc_reg, pc_next;

  logic        is_c, sel_m, zx, nx, zy, ny, fn, no;
  logic        dest_a, dest_d, dest_m, jlt, jeq, jgt;
  logic [15:0] m_val, y_src, x_z, x_n, y_z, y_n, alu_r, alu_out;
  logic        zr, ng, jump;

  assign is_c   = inst[15];
  assign sel_m  = inst[12];
  assign zx     = inst[11];
  assign nx     = inst[10];
  assign zy     = inst[9];
  assign ny     = inst[8];
  assign fn     = inst[7];
  assign no     = inst[6];
  assign dest_a = inst[5];
  assign dest_d = inst[4];
  assign dest_m = inst[3];
  assign jlt    = inst[2];
  assign jeq    = inst[1];
  assign jgt    = inst[0];

  assign inst_addr = pc_reg[9:0];
  assign data_addr = a_reg[9:0];

  // The switch word shadows whatever the RAM returns at 0x6000.
  assign m_val = (a_reg == 16'h6000) ? {12'h000, SW} : in_m;
  assign y_src = sel_m ? m_val : a_reg;

  always_comb begin
    x_z     = zx ? 16'h0000 : d_reg;
    x_n     = nx ? ~x_z : x_z;
    y_z     = zy ? 16'h0000 : y_src;
    y_n     = ny ? ~y_z : y_z;
    alu_r   = fn ? (x_n + y_n) : (x_n & y_n);
    alu_out = no ? ~alu_r : alu_r;
    zr      = (alu_out == 16'h0000);
    ng      = alu_out[15];
    jump    = (jlt & ng) | (jeq & zr) | (jgt & ~ng & ~zr);
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_reg <= FETCH;
      a_reg     <= 16'h0000;
      d_reg     <= 16'h0000;
      pc_reg    <= 15'h0000;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      d_reg     <= d_next;
      pc_reg    <= pc_next;
    end
  end

  // ALU operands and the jump target come from the pre-instruction registers.
  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    d_next     = d_reg;
    pc_next    = pc_reg;
    write_m    = 1'b0;
    out_m      = 16'h0000;
    case (state_reg)
      FETCH: state_next = EXEC;
      EXEC: begin
        state_next = FETCH;
        pc_next    = pc_reg + 15'd1;
        if (!is_c) begin
          a_next = {1'b0, inst[14:0]};
        end else begin
          out_m   = alu_out;
          write_m = dest_m && (a_reg[15:10] == 6'd0);
          if (dest_a) a_next = alu_out;
          if (dest_d) d_next = alu_out;
          if (jump)   pc_next = a_reg[14:0];
        end
      end
      default: state_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_cpu.sv
// Bench for cpu: directed Hack programs plus random programs, scored against an instruction-level ISA model.
// Expected outcomes are queued when an instruction is issued. A separate monitor checks the outputs in each EXEC and FETCH cycle.
module tb_cpu;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic [3:0]  SW = 4'h0;
  logic [15:0] inst, in_m, out_m;
  logic        write_m;
  logic [9:0]  data_addr, inst_addr;

  cpu dut (
    .clk(clk), .resetN(resetN), .SW(SW), .inst(inst), .in_m(in_m),
    .out_m(out_m), .write_m(write_m), .data_addr(data_addr), .inst_addr(inst_addr)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [1024];
  logic [15:0] tb_ram [1024];
  logic [15:0] ram_init [1024];
  logic [15:0] m_ram [1024];
  logic        ram_load = 1'b0;

  // Synchronous ROM and RAM with a one-cycle read latency.
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 1024; i++) tb_ram[i] <= ram_init[i];
    end else if (write_m) begin
      tb_ram[data_addr] <= out_m;
    end
    inst <= rom[inst_addr];
    in_m <= tb_ram[data_addr];
  end

  typedef struct {
    bit          is_c;
    bit          wr;
    logic [9:0]  addr;
    logic [15:0] out;
    logic [14:0] pc;
    logic [15:0] a;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          txn = 0;
  logic [15:0] m_a, m_d;
  logic [14:0] m_pc;
  logic [3:0]  m_sw;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ISA-level reference model: this task executes one whole instruction.
  task automatic model_step(output exp_t e);
    logic [15:0] ins, x, y, r, o;
    logic        taken;
    ins    = rom[m_pc[9:0]];
    e.is_c = ins[15];
    e.wr   = 1'b0;
    e.addr = m_a[9:0];
    e.out  = 16'h0000;
    if (!ins[15]) begin
      m_a  = {1'b0, ins[14:0]};
      m_pc = m_pc + 15'd1;
    end else begin
      x = m_d;
      if (ins[12]) y = (m_a == 16'h6000) ? {12'h000, m_sw} : m_ram[m_a[9:0]];
      else         y = m_a;
      if (ins[11]) x = 16'h0000;
      if (ins[10]) x = ~x;
      if (ins[9])  y = 16'h0000;
      if (ins[8])  y = ~y;
      r = ins[7] ? x + y : x & y;
      o = ins[6] ? ~r : r;
      taken = (ins[2] && o[15]) || (ins[1] && o == 16'h0000) ||
              (ins[0] && !o[15] && o != 16'h0000);
      e.out = o;
      e.wr  = ins[3] && (m_a < 16'h0400);
      if (e.wr) m_ram[m_a[9:0]] = o;
      m_pc = taken ? m_a[14:0] : m_pc + 15'd1;
      if (ins[5]) m_a = o;
      if (ins[4]) m_d = o;
    end
    e.pc = m_pc;
    e.a  = m_a;
  endtask

  task automatic issue(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step(e);
      exp_q.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic monitor(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard: got empty queue expected an entry at txn %0d", txn);
      end else begin
        e = exp_q.pop_front();
        check("exec write_m", 32'(write_m), 32'(e.wr));
        if (e.is_c) check("exec out_m", 32'(out_m), 32'(e.out));
        if (e.wr)   check("exec data_addr", 32'(data_addr), 32'(e.addr));
        @(posedge clk);
        @(negedge clk);
        check("fetch inst_addr", 32'(inst_addr), 32'(e.pc[9:0]));
        check("fetch data_addr", 32'(data_addr), 32'(e.a[9:0]));
        check("fetch write_m", 32'(write_m), 32'd0);
        check("fetch out_m", 32'(out_m), 32'd0);
        $display("txn %0d: c=%0d wr=%0d addr=%0h out=%0h pc=%0h a=%0h",
                 txn, e.is_c, e.wr, e.addr, e.out, e.pc, e.a);
      end
      txn++;
    end
  endtask

  task automatic run(input int n);
    fork
      issue(n);
      monitor(n);
    join
  endtask

  task automatic start(input logic [3:0] sw_val);
    @(negedge clk);
    resetN   = 1'b0;
    SW       = sw_val;
    ram_load = 1'b1;
    #1;
    check("reset write_m", 32'(write_m), 32'd0);
    check("reset out_m", 32'(out_m), 32'd0);
    check("reset inst_addr", 32'(inst_addr), 32'd0);
    check("reset data_addr", 32'(data_addr), 32'd0);
    @(posedge clk);
    #1;
    ram_load = 1'b0;
    m_a   = 16'h0000;
    m_d   = 16'h0000;
    m_pc  = 15'h0000;
    m_sw  = sw_val;
    m_ram = ram_init;
    exp_q.delete();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  task automatic compare_ram(input string name);
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      if (tb_ram[i] !== m_ram[i]) begin
        if (bad == 0) $display("FAIL %s: ram[%0d] got %0h expected %0h", name, i, tb_ram[i], m_ram[i]);
        bad++;
      end
    end
    checks++;
    if (bad != 0) errors++;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) begin
      rom[i]      = 16'h0000;
      ram_init[i] = 16'($urandom);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    if ($urandom_range(0, 9) < 4) begin
      case ($urandom_range(0, 5))
        0:       v = 16'h6000;
        1:       v = {1'b0, 15'($urandom)};
        default: v = 16'($urandom_range(0, 63));
      endcase
    end else begin
      v = 16'($urandom);
      v[15] = 1'b1;
    end
    return v;
  endfunction

  initial begin
    // Load 5, copy it to D, then store D to RAM[3].
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0003; rom[3] = 16'hE308;
    start(4'h0);
    run(4);
    check("store ram[3]", 32'(tb_ram[3]), 32'h5);
    compare_ram("store ram");

    // D overflows to 0x8000. D;JLT is then taken, and after D=0 it falls through.
    clear_mem();
    rom[0] = 16'h7FFF; rom[1] = 16'hEC10; rom[2] = 16'hE7D0; rom[3] = 16'h000A; rom[4] = 16'hE304;
    rom[10] = 16'hEA90; rom[11] = 16'h0014; rom[12] = 16'hE304;
    start(4'h0);
    run(5);
    check("jlt taken pc", 32'(inst_addr), 32'd10);
    run(3);
    check("jlt not taken pc", 32'(inst_addr), 32'd13);

    // Read the switch word, store it to RAM[7], then try a dropped write at 0x6000.
    clear_mem();
    rom[0] = 16'h6000; rom[1] = 16'hFC10; rom[2] = 16'h0007; rom[3] = 16'hE308;
    rom[4] = 16'h6000; rom[5] = 16'hEFC8;
    start(4'hA);
    run(6);
    check("switch ram[7]", 32'(tb_ram[7]), 32'h000A);
    check("dropped write ram[0]", 32'(tb_ram[0]), 32'(ram_init[0]));
    compare_ram("switch ram");

    // AM=M+1 writes through the old A, and the new A becomes the result.
    clear_mem();
    ram_init[20] = 16'h0007;
    rom[0] = 16'h0014; rom[1] = 16'hFDE8;
    start(4'($urandom));
    run(2);
    check("am ram[20]", 32'(tb_ram[20]), 32'h0008);
    check("am data_addr", 32'(data_addr), 32'h8);

    // Take an unconditional jump, then abort a pending M=1 write with reset.
    clear_mem();
    ram_init[5] = 16'h1234;
    rom[0] = 16'h0006; rom[1] = 16'hEA87; rom[6] = 16'h0005; rom[7] = 16'hEFC8;
    start(4'h0);
    run(2);
    check("jmp pc", 32'(inst_addr), 32'd6);
    run(1);
    @(posedge clk);
    @(negedge clk);
    check("pre-abort write_m", 32'(write_m), 32'd1);
    resetN = 1'b0;
    #1;
    check("abort write_m", 32'(write_m), 32'd0);
    check("abort out_m", 32'(out_m), 32'd0);
    check("abort inst_addr", 32'(inst_addr), 32'd0);
    check("abort data_addr", 32'(data_addr), 32'd0);
    @(posedge clk);
    #1;
    check("abort ram[5]", 32'(tb_ram[5]), 32'h1234);

    // Random programs.
    for (int p = 0; p < 6; p++) begin
      clear_mem();
      for (int i = 0; i < 1024; i++) rom[i] = rand_instr();
      start(4'($urandom));
      run(120);
      compare_ram("random ram");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001: Clock and reset SHALL be clk (single clock) and resetN (asynchronous, active-low).
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: resetN  input  1  asynchronous active-low reset.
REQ-004: SW  input  4  switch value, readable as a memory-mapped input word.
REQ-005: inst  input  16  instruction word from a synchronous ROM, valid one cycle after inst_addr is sampled.
REQ-006: in_m  input  16  data word from a synchronous RAM, valid one cycle after data_addr is sampled.
REQ-007: out_m  output  16  data to write to RAM.
REQ-008: write_m  output  1  RAM write enable, sampled with data_addr and out_m on the rising clk edge.
REQ-009: data_addr  output  10  RAM word address.
REQ-010: inst_addr  output  10  ROM word address.

Function
REQ-011: The CPU SHALL implement the 16-bit Hack ISA with registers A (16b), D (16b) and PC (15b).
REQ-012: Two-state FSM: FETCH -> EXEC -> FETCH; each instruction takes exactly 2 clk cycles; no stalls.
REQ-013: inst_addr SHALL be PC[9:0] and data_addr SHALL be A[9:0], both combinational from the registers.
REQ-014: In FETCH no architectural state changes; write_m=0 and out_m=0.
REQ-015: In EXEC, inst and in_m are consumed; A, D and PC update on the rising edge that ends EXEC.
REQ-016: A-instruction (inst[15]=0): A <= {1'b0, inst[14:0]}; D unchanged; PC <= PC+1; write_m=0.
REQ-017: C-instruction (inst[15]=1) fields: a=inst[12], zx/nx/zy/ny/f/no=inst[11:6], dA=inst[5], dD=inst[4], dM=inst[3], jlt/jeq/jgt=inst[2:0]; inst[14:13] ignored.
REQ-018: ALU x=D; y = M if a=1, else A.
REQ-019: ALU pipeline: x'=zx?0:x, then nx?~x'; y'=zy?0:y, then ny?~y'; r=f?(x'+y') mod 2^16:(x'&y'); out=no?~r:r.
REQ-020: zr = (out==0); ng = out[15].
REQ-021: M = {12'b0, SW} when A==16'h6000; otherwise M = in_m.
REQ-022: In EXEC for a C-instruction, out_m SHALL equal the ALU out.
REQ-023: write_m SHALL equal dM AND (A[15:10]==0), so writes outside the 1K RAM range (including 0x6000) are dropped.
REQ-024: The RAM write uses the pre-instruction A.
REQ-025: Destinations: dA -> A<=out; dD -> D<=out; multiple destinations update simultaneously from the same out.
REQ-026: An ALU input read of A or D uses the old value even when that register is also a destination.
REQ-027: Jump taken = (jlt&ng) | (jeq&zr) | (jgt&~ng&~zr).
REQ-028: If the jump is taken, PC <= pre-instruction A[14:0] (not the newly written A); otherwise PC <= PC+1.
REQ-029: PC SHALL wrap modulo 2^15; inst_addr aliases modulo 1024.
REQ-030: The CPU SHALL run continuously; halting is done externally by gating clk, with no internal halt state.

Reset
REQ-031: While resetN=0: A=0, D=0, PC=0, FSM=FETCH, write_m=0, out_m=0, inst_addr=0, data_addr=0; the effect is immediate and asynchronous.
REQ-032: Reset asserted mid-instruction SHALL abort it with no A/D/PC update and no write.
REQ-033: After resetN rises, the first edge SHALL be FETCH of address 0, with the first EXEC in the following cycle.

Verification
REQ-034: ROM {0x0005, 0xEC10 (D=A), 0x0003, 0xE308 (M=D)} -> after 8 cycles RAM[3]=5; write_m high only in cycle 8 (EXEC of instr 4) with data_addr=3 and out_m=5.
REQ-035: D=0x7FFF then D=D+1 (0xE7D0) -> D=0x8000 (wrap to negative); then @10 and D;JLT (0xE304) -> PC=10; with D=0, D;JLT -> PC=PC+1.
REQ-036: SW=4'hA, @0x6000, D=M (0xFC10) -> D=0x000A; @0x6000 then M=1 (0xEFC8) -> write_m stays 0.
REQ-037: @20 then AM=M+1 (0xFDE8) with RAM[20]=7 -> write at address 20 with value 8, then A=8 and data_addr=8.
REQ-038: @6, 0;JMP (0xEA87) -> PC=6; then pulse resetN low during EXEC of any instruction -> A=D=PC=0 and write_m=0 immediately, with no RAM write.
